// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
package reset_seq_pkg;

  // Sequencer phases: everything held, staggered release, all released.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Reason recorded for the most recent reset.
  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_BTN  = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_seq_debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// The output level only changes after the synchronised input has disagreed
// with it for CYCLES consecutive clocks; any reversion restarts the count.
module debounce_sync #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync_a_reg;
  logic             sync_b_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Bring the raw asynchronous input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_reg <= 1'b0;
      sync_b_reg <= 1'b0;
    end else begin
      sync_a_reg <= din;
      sync_b_reg <= sync_a_reg;
    end
  end

  // Count consecutive disagreeing cycles; flip the level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (sync_b_reg == level_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      level_reg <= sync_b_reg;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign dout = level_reg;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: qualifies PLL lock, an armed push-button and a software
// request, holds all reset outputs, then releases them one at a time with a
// fixed stagger (bit 0 first), and records why the last reset happened.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT         = 3,
  parameter int HOLD_CYCLES     = 32,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SEL_W           = 4,
  parameter int BTN_SEL         = 1
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               locked_i,
  input  logic               btn_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               sw_req_i,
  output logic [NUM_OUT-1:0] reset_o,
  output logic               ready_o,
  output logic [1:0]         cause_o
);

  localparam int CNT_W = width_for(max_int(HOLD_CYCLES, STAGGER_CYCLES));
  localparam int IDX_W = width_for(NUM_OUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [SEL_W-1:0] SEL_ARM   = SEL_W'(BTN_SEL);

  logic               lock_a_reg;
  logic               locked_s_reg;
  logic               locked_prev_reg;
  logic               btn_hold_prev_reg;
  logic               btn_db;
  logic               btn_hold;
  logic               ok;
  logic               lock_fall;
  logic               btn_rise;
  logic               any_req;

  state_t             state_reg, state_next;
  cause_t             cause_reg, cause_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_OUT-1:0] rst_reg, rst_next;
  logic               ready_reg, ready_next;

  debounce_sync #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (reset_n_i),
    .din   (btn_i),
    .dout  (btn_db)
  );

  // Synchronise PLL lock and keep previous levels for edge detection.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_a_reg        <= 1'b0;
      locked_s_reg      <= 1'b0;
      locked_prev_reg   <= 1'b0;
      btn_hold_prev_reg <= 1'b0;
    end else begin
      lock_a_reg        <= locked_i;
      locked_s_reg      <= lock_a_reg;
      locked_prev_reg   <= locked_s_reg;
      btn_hold_prev_reg <= btn_hold;
    end
  end

  // The selector gates the debounced level, so arming while held is a rise.
  assign btn_hold  = btn_db && (sel_i == SEL_ARM);
  assign ok        = locked_s_reg && !btn_hold;
  assign lock_fall = locked_prev_reg && !locked_s_reg;
  assign btn_rise  = btn_hold && !btn_hold_prev_reg;
  assign any_req   = lock_fall || btn_rise || sw_req_i;

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= ASSERT;
      cause_reg <= CAUSE_POR;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rst_reg   <= '1;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
    end
  end

  // Next-state: requests override everything, otherwise hold/release/run.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;

    if (any_req) begin
      state_next = ASSERT;
      cnt_next   = '0;
      idx_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
      if (lock_fall) begin
        cause_next = CAUSE_LOCK;
      end else if (btn_rise) begin
        cause_next = CAUSE_BTN;
      end else begin
        cause_next = CAUSE_SW;
      end
    end else begin
      case (state_reg)
        ASSERT: begin
          rst_next   = '1;
          ready_next = 1'b0;
          if (!ok) begin
            cnt_next = '0;
          end else if (cnt_reg == HOLD_LAST) begin
            cnt_next    = '0;
            rst_next[0] = 1'b0;
            if (NUM_OUT == 1) begin
              state_next = RUN;
              ready_next = 1'b1;
            end else begin
              state_next = RELEASE;
              idx_next   = IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_reg == STAG_LAST) begin
            cnt_next = '0;
            rst_next = rst_reg << 1;
            if (idx_reg == IDX_LAST) begin
              state_next = RUN;
              ready_next = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          rst_next   = '0;
          ready_next = 1'b1;
        end
        default: begin
          state_next = ASSERT;
          rst_next   = '1;
          ready_next = 1'b0;
        end
      endcase
    end
  end

  assign reset_o = rst_reg;
  assign ready_o = ready_reg;
  assign cause_o = cause_reg;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: a table of {inputs, cycles, expected outputs}
// plus hand sequences for asynchronous reset and late PLL lock.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       locked_i;
  logic       btn_i;
  logic [3:0] sel_i;
  logic       sw_req_i;
  logic [2:0] reset_o;
  logic       ready_o;
  logic [1:0] cause_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         n;
    logic       lk;
    logic       bt;
    logic [3:0] sl;
    logic       sw;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] cs;
  } vec_t;

  vec_t vecs[$];

  reset_seq #(
    .NUM_OUT         (3),
    .HOLD_CYCLES     (32),
    .STAGGER_CYCLES  (4),
    .DEBOUNCE_CYCLES (4),
    .SEL_W           (4),
    .BTN_SEL         (1)
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .locked_i  (locked_i),
    .btn_i     (btn_i),
    .sel_i     (sel_i),
    .sw_req_i  (sw_req_i),
    .reset_o   (reset_o),
    .ready_o   (ready_o),
    .cause_o   (cause_o)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic lk, input logic bt, input logic [3:0] sl,
                     input logic sw, input logic [2:0] rst, input logic rdy, input logic [1:0] cs);
    vec_t v;
    v.n = n; v.lk = lk; v.bt = bt; v.sl = sl; v.sw = sw;
    v.rst = rst; v.rdy = rdy; v.cs = cs;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h, expected %0h", what, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [2:0] r,
                         input logic rd, input logic [1:0] c);
    $display("%s #%0d: reset_o=%b ready_o=%b cause_o=%0d (want %b %b %0d)",
             tag, idx, reset_o, ready_o, cause_o, r, rd, c);
    chk({tag, ".reset_o"}, idx, {5'b0, reset_o}, {5'b0, r});
    chk({tag, ".ready_o"}, idx, {7'b0, ready_o}, {7'b0, rd});
    chk({tag, ".cause_o"}, idx, {6'b0, cause_o}, {6'b0, c});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // n, locked, btn, sel, sw, reset_o, ready_o, cause_o
    // start-up with lock already present: bit0 @34, bit1 @38, bit2 @42
    add(33, 1, 0, 4'd1, 0, 3'b111, 0, 2'd0);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd0);
    add( 3, 1, 0, 4'd1, 0, 3'b110, 0, 2'd0);
    add( 1, 1, 0, 4'd1, 0, 3'b100, 0, 2'd0);
    add( 3, 1, 0, 4'd1, 0, 3'b100, 0, 2'd0);
    add( 1, 1, 0, 4'd1, 0, 3'b000, 1, 2'd0);
    add( 5, 1, 0, 4'd1, 0, 3'b000, 1, 2'd0);
    // one-cycle lock drop: asserted 3 cycles later, full replay
    add( 1, 0, 0, 4'd1, 0, 3'b000, 1, 2'd0);
    add( 1, 1, 0, 4'd1, 0, 3'b000, 1, 2'd0);
    add( 1, 1, 0, 4'd1, 0, 3'b111, 0, 2'd1);
    add(31, 1, 0, 4'd1, 0, 3'b111, 0, 2'd1);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd1);
    add( 4, 1, 0, 4'd1, 0, 3'b100, 0, 2'd1);
    add( 4, 1, 0, 4'd1, 0, 3'b000, 1, 2'd1);
    // 2-cycle glitch is filtered
    add( 2, 1, 1, 4'd1, 0, 3'b000, 1, 2'd1);
    add( 6, 1, 0, 4'd1, 0, 3'b000, 1, 2'd1);
    // 8-cycle armed press: asserts at edge 7, releases 32 edges after db falls
    add( 6, 1, 1, 4'd1, 0, 3'b000, 1, 2'd1);
    add( 1, 1, 1, 4'd1, 0, 3'b111, 0, 2'd2);
    add( 1, 1, 1, 4'd1, 0, 3'b111, 0, 2'd2);
    add(37, 1, 0, 4'd1, 0, 3'b111, 0, 2'd2);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd2);
    add( 4, 1, 0, 4'd1, 0, 3'b100, 0, 2'd2);
    add( 4, 1, 0, 4'd1, 0, 3'b000, 1, 2'd2);
    // same press, disarmed selector: no effect
    add( 8, 1, 1, 4'd0, 0, 3'b000, 1, 2'd2);
    add(10, 1, 0, 4'd0, 0, 3'b000, 1, 2'd2);
    // software request in RUN
    add( 1, 1, 0, 4'd1, 1, 3'b111, 0, 2'd3);
    add(31, 1, 0, 4'd1, 0, 3'b111, 0, 2'd3);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd3);
    // software request in RELEASE restarts the full hold
    add( 1, 1, 0, 4'd1, 1, 3'b111, 0, 2'd3);
    add(31, 1, 0, 4'd1, 0, 3'b111, 0, 2'd3);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd3);
    add( 8, 1, 0, 4'd1, 0, 3'b000, 1, 2'd3);
    // arming the selector while already held is a button event
    add( 8, 1, 1, 4'd0, 0, 3'b000, 1, 2'd3);
    add( 1, 1, 1, 4'd1, 0, 3'b111, 0, 2'd2);
    add( 1, 1, 1, 4'd1, 0, 3'b111, 0, 2'd2);
    // disarming while held lets the hold count run
    add(31, 1, 1, 4'd0, 0, 3'b111, 0, 2'd2);
    add( 1, 1, 1, 4'd0, 0, 3'b110, 0, 2'd2);
    add( 8, 1, 0, 4'd0, 0, 3'b000, 1, 2'd2);
    add( 8, 1, 0, 4'd1, 0, 3'b000, 1, 2'd2);
    // lock loss and software request on the same edge: lock wins
    add( 1, 0, 0, 4'd1, 0, 3'b000, 1, 2'd2);
    add( 1, 1, 0, 4'd1, 0, 3'b000, 1, 2'd2);
    add( 1, 1, 0, 4'd1, 1, 3'b111, 0, 2'd1);
    add(31, 1, 0, 4'd1, 0, 3'b111, 0, 2'd1);
    add( 1, 1, 0, 4'd1, 0, 3'b110, 0, 2'd1);

    reset_n_i = 1'b0;
    locked_i  = 1'b1;
    btn_i     = 1'b0;
    sel_i     = 4'd1;
    sw_req_i  = 1'b0;
    repeat (3) tick();
    chk_all("in_reset", 0, 3'b111, 1'b0, 2'd0);
    reset_n_i = 1'b1;

    foreach (vecs[i]) begin
      locked_i = vecs[i].lk;
      btn_i    = vecs[i].bt;
      sel_i    = vecs[i].sl;
      sw_req_i = vecs[i].sw;
      repeat (vecs[i].n) tick();
      chk_all("vec", i, vecs[i].rst, vecs[i].rdy, vecs[i].cs);
    end
    sw_req_i = 1'b0;

    // mid-RELEASE asynchronous reset takes effect without a clock edge
    tick();
    chk_all("mid_release", 0, 3'b110, 1'b0, 2'd1);
    #2 reset_n_i = 1'b0;
    #1 chk_all("async_reset", 0, 3'b111, 1'b0, 2'd0);
    locked_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;

    // late lock: bit 0 releases 34 edges after locked_i rises
    repeat (10) tick();
    chk_all("late_lock_wait", 0, 3'b111, 1'b0, 2'd0);
    locked_i = 1'b1;
    repeat (33) tick();
    chk_all("late_lock_hold", 0, 3'b111, 1'b0, 2'd0);
    tick();
    chk_all("late_lock_rel", 0, 3'b110, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised reset sequencer generalising the board-level auto-reset counter. It qualifies PLL lock, a debounced, selector-gated push-button and a software request. It drives NUM_OUT active-high reset outputs that assert together and release one by one in staggered order, so SDRAM, video and CPU domains leave reset in a fixed sequence. It sits in each board top between the PLL and the SoC `reset_i` inputs, and records the cause of the last reset.

## Interface
- NUM_OUT, 3: number of reset outputs, 1..16; bit 0 releases first.
- HOLD_CYCLES, 32: cycles all outputs stay asserted once hold conditions are met; ≥1.
- STAGGER_CYCLES, 4: cycles between successive output releases; ≥1.
- DEBOUNCE_CYCLES, 250000: cycles the synchronised button must be stable before its debounced level changes; ≥1.
- SEL_W, 4: width of the button selector.
- BTN_SEL, 1: selector value that arms the button.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- locked_i  in  1  PLL lock, asynchronous; 2-FF synchronised.
- btn_i  in  1  raw button, asynchronous, active-high.
- sel_i  in  SEL_W  selector; button is armed only while sel_i == BTN_SEL.
- sw_req_i  in  1  synchronous one-cycle software reset request.
- reset_o  out  NUM_OUT  active-high reset outputs, registered.
- ready_o  out  1  high when all outputs are released.
- cause_o  out  2  last reset cause: 0 power-on, 1 lock loss, 2 button, 3 software.

## Operation
- Reset values (reset_n_i low): state ASSERT; reset_o all ones; ready_o 0; cause_o 0; counter 0; release index 0; sync flops and debounced level 0.
- Inputs:
  - locked_s: locked_i through 2 flops.
  - btn_db: btn_i through 2 flops, then the debouncer. btn_db follows the synchronised value only after it differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any reversion resets the debounce count.
  - btn_hold = btn_db && (sel_i == BTN_SEL).
- Hold condition ok = locked_s && !btn_hold.
- Request events: lock loss (locked_s falls), button (btn_hold rises), software (sw_req_i).
- States:
  - ASSERT: reset_o all ones, ready_o 0.
    - If !ok, counter is cleared.
    - Otherwise the counter increments.
    - When the counter reaches HOLD_CYCLES-1 with ok high, the next edge clears reset_o[0] and zeroes the counter. The state becomes RELEASE, or RUN if NUM_OUT==1.
  - RELEASE: the counter increments. At STAGGER_CYCLES-1 the next edge clears the next reset_o bit and zeroes the counter. The edge that clears bit NUM_OUT-1 also enters RUN and sets ready_o.
  - RUN: reset_o all zero, ready_o 1.
- Any request event in any state behaves as follows on the next edge:
  - state becomes ASSERT, reset_o all ones, ready_o 0, counter 0;
  - cause_o is updated.
- A request during ASSERT restarts the hold count.
- Simultaneous events set cause_o by priority: lock loss > button > software.
- A button held indefinitely keeps ASSERT; counting begins when btn_hold falls.
- Changing sel_i away from BTN_SEL while the button is held lets counting start. Changing sel_i to match while the button is already held is a button event.

## Timing
- Reset outputs assert within 1 cycle of any request event; they assert immediately and asynchronously on reset_n_i.
- Start-up: reset_n_i released, locked_i already high. locked_s is high after edge 2. reset_o[0] falls at edge 2+HOLD_CYCLES.
- Bit k falls k*STAGGER_CYCLES edges after bit 0. ready_o rises on the same edge as bit NUM_OUT-1.
- Button path latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle to assert.
- Counter width: $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)); it never wraps.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).

## Structure
- Package reset_seq_pkg holds the state enum (ASSERT, RELEASE, RUN) and the cause enum (CAUSE_POR, CAUSE_LOCK, CAUSE_BTN, CAUSE_SW).
- One sub-module, debounce_sync: 2-FF synchroniser plus stable-count debouncer, parameter CYCLES, async active-low reset. It is reusable for PS/2 and other buttons.

## Test plan
- Start-up:
  - Stimulus: NUM_OUT=3, HOLD=32, STAGGER=4, locked_i high; release reset_n_i.
  - Required: reset_o = 111 until edge 34, then 110, then 100 at edge 38, then 000 with ready_o=1 at edge 42; cause_o=0.
- Late lock:
  - Stimulus: locked_i rises 10 cycles after reset release.
  - Required: reset_o[0] falls 2+32 edges after the rise.
- Lock loss:
  - Stimulus: drop locked_i in RUN for 1 cycle.
  - Required: reset_o=111 and ready_o=0 3 cycles after the drop; cause_o=1; full sequence replays.
- Button and selector (DEBOUNCE=4):
  - Stimulus: 2-cycle glitch, then an 8-cycle press with sel_i=1.
  - Required: the glitch is ignored; the press asserts with cause_o=2 and holds until release plus debounce.
  - Stimulus: the same press with sel_i=0.
  - Required: no effect.
- Software request:
  - Stimulus: sw_req_i pulse in RELEASE, after bit 0 has cleared.
  - Required: reset_o=111 next edge; cause_o=3; hold restarts from 0.
- Simultaneous events:
  - Stimulus: sw_req_i and lock loss on the same edge.
  - Required: cause_o=1.
- Mid-operation reset:
  - Stimulus: reset_n_i pulsed low mid-RELEASE.
  - Required: immediate 111, cause_o=0.
